exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception arbitration and commit stage sitting at the end of the MEM stage, directly upstream of the CP0 register file. Synchronises the external interrupt lines, masks them against CP0 Status/Cause, priority-encodes the per-instruction exception flags into the CP0 exception code, and registers the exception record that CP0 samples. Drives the pipeline flush and redirect PC, holding flush for a fixed number of cycles during which no further exception is accepted.

## Interface
- EXC_ENTRY, 32'hBFC00380, redirect PC for every exception except eret
- FLUSH_CYCLES, 2, cycles flush_o stays high per accepted event (>=1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- int_i  in  6  raw external interrupt lines, asynchronous to clk
- mem_valid_i  in  1  MEM-stage instruction valid
- stall_i  in  1  MEM stage stalled; no event accepted while high
- mem_pc_i  in  32  PC of MEM-stage instruction
- mem_addr_i  in  32  data address of MEM-stage load/store
- mem_in_delayslot_i  in  1  instruction is in a branch delay slot
- adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_i, ades_i, eret_i  in  1 each  exception flags from earlier stages
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 registers
- int_sync_o  out  6  synchronised int_i, to CP0 int_i
- excepttype_o  out  32  CP0 exception code, one-cycle pulse
- cp0_pc_o  out  32  PC of faulting instruction
- is_in_delayslot_o  out  1  delay-slot flag of faulting instruction
- bad_addr_o  out  32  faulting address for codes 4/5
- flush_o  out  1  pipeline flush
- new_pc_o  out  32  redirect PC, valid while flush_o high
- busy_o  out  1  high in FLUSH state

## Operation
- Sync: two-flop synchroniser per int_i bit; int_sync_o is second flop.
- Interrupt pending: status[0]=1 and status[1]=0 and |(cause[15:8] & status[15:8]).
- Accept condition: state IDLE, mem_valid_i=1, stall_i=0, and (interrupt pending or any flag set).
- Priority, highest first, with code: interrupt 0x1; adel_if 0x4; ri 0xa; ov 0xc; trap 0xd; syscall 0x8; break 0x9; adel 0x4; ades 0x5; eret 0xe. Only the winner is reported.
- bad_addr: adel_if winner -> mem_pc_i; adel/ades winner -> mem_addr_i; otherwise hold previous value.
- new_pc: eret -> cp0_epc_i sampled at accept; all others -> EXC_ENTRY.
- cp0_pc_o/is_in_delayslot_o capture mem_pc_i/mem_in_delayslot_i at accept; CP0 applies the delay-slot -4 adjustment.
- FSM: IDLE -> FLUSH on accept; FLUSH counts FLUSH_CYCLES cycles then -> IDLE. Flags and interrupts ignored in FLUSH (flushed instructions never report).
- Zero-extend all codes to 32 bits; excepttype_o is 0 whenever no event is reported.

## Timing
- Reset (rst low, async): state IDLE, counter 0, sync flops 0, all outputs 0.
- Accept at edge N: at N+1 excepttype_o, cp0_pc_o, is_in_delayslot_o, bad_addr_o, new_pc_o, flush_o, busy_o all valid; excepttype_o returns to 0 at N+2.
- flush_o/busy_o high for exactly FLUSH_CYCLES cycles; first new accept possible at the edge they drop.
- CP0 samples on negedge, mid-cycle of the excepttype_o pulse.
- int_i to int_sync_o: 2 cycles; to pending/accept: +0 once CP0 cause reflects it (CP0 adds its own cycle).
- Simultaneous interrupt and eret/syscall: interrupt wins, eret discarded.
- stall_i high with flags present: no accept, outputs unchanged; accept on first unstalled cycle.
- rst low mid-FLUSH: flush_o drops immediately, counter cleared.

## Test plan
- Reset: hold rst low, toggle inputs -> all outputs 0, busy_o 0; release -> IDLE.
- syscall_i=1, mem_pc_i=0xBFC00100, delayslot=0 -> next cycle excepttype_o=0x8, cp0_pc_o=0xBFC00100, new_pc_o=0xBFC00380, flush_o high 2 cycles, excepttype_o 0 after 1.
- adel_i=1 and ov_i=1, mem_addr_i=0x00000003 -> code 0xc, bad_addr_o unchanged; then adel_i alone -> code 0x4, bad_addr_o=0x00000003.
- eret_i=1, cp0_epc_i=0x80001234 -> code 0xe, new_pc_o=0x80001234; second eret in next cycle ignored (busy).
- int_i[0] set, status=0x0000_0401, cause[10]=1 -> with break_i=1 same cycle code 0x1; with status[1]=1 -> break reported (0x9).
- stall_i=1 with ri_i=1 for 3 cycles -> no outputs; stall_i drops -> code 0xa next cycle; rst pulse mid-flush clears flush_o asynchronously.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception arbitration/commit stage between MEM and CP0: synchronises interrupts,
// picks the winning exception, registers the CP0 record and drives flush/redirect.
module exc_ctrl #(
    parameter logic [31:0] EXC_ENTRY    = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        mem_valid_i,
    input  logic        stall_i,
    input  logic [31:0] mem_pc_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_in_delayslot_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        trap_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        adel_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  int_sync_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] cp0_pc_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]      int_meta_q, int_meta_d;
    logic [5:0]      int_sync_q, int_sync_d;
    logic [4:0]      code_q, code_d;
    logic [31:0]     cp0_pc_q, cp0_pc_d;
    logic            ds_q, ds_d;
    logic [31:0]     bad_addr_q, bad_addr_d;
    logic [31:0]     new_pc_q, new_pc_d;

    logic            irq_pending;
    logic            any_flag;
    logic            accept;
    logic [4:0]      win_code;
    logic            win_bad_pc;
    logic            win_bad_addr;
    logic            win_eret;

    // Status/Cause bits outside IE/EXL and the IM/IP fields play no part here.
    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                               cp0_cause_i[31:16], cp0_cause_i[7:0]};

    always_comb begin
        irq_pending = cp0_status_i[0] & ~cp0_status_i[1]
                    & (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));
        any_flag    = adel_if_i | ri_i | ov_i | trap_i | syscall_i
                    | break_i | adel_i | ades_i | eret_i;
        accept      = (state_q == S_IDLE) & mem_valid_i & ~stall_i
                    & (irq_pending | any_flag);
    end

    always_comb begin
        win_code     = 5'h00;
        win_bad_pc   = 1'b0;
        win_bad_addr = 1'b0;
        win_eret     = 1'b0;
        if (irq_pending) begin
            win_code = 5'h01;
        end else if (adel_if_i) begin
            win_code   = 5'h04;
            win_bad_pc = 1'b1;
        end else if (ri_i) begin
            win_code = 5'h0a;
        end else if (ov_i) begin
            win_code = 5'h0c;
        end else if (trap_i) begin
            win_code = 5'h0d;
        end else if (syscall_i) begin
            win_code = 5'h08;
        end else if (break_i) begin
            win_code = 5'h09;
        end else if (adel_i) begin
            win_code     = 5'h04;
            win_bad_addr = 1'b1;
        end else if (ades_i) begin
            win_code     = 5'h05;
            win_bad_addr = 1'b1;
        end else if (eret_i) begin
            win_code = 5'h0e;
            win_eret = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = 5'h00;
        cp0_pc_d   = cp0_pc_q;
        ds_d       = ds_q;
        bad_addr_d = bad_addr_q;
        new_pc_d   = new_pc_q;
        int_meta_d = int_i;
        int_sync_d = int_meta_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_FLUSH;
                    cnt_d    = '0;
                    code_d   = win_code;
                    cp0_pc_d = mem_pc_i;
                    ds_d     = mem_in_delayslot_i;
                    new_pc_d = win_eret ? cp0_epc_i : EXC_ENTRY;
                    if (win_bad_pc) begin
                        bad_addr_d = mem_pc_i;
                    end else if (win_bad_addr) begin
                        bad_addr_d = mem_addr_i;
                    end
                end
            end
            S_FLUSH: begin
                // Instructions seen during flush are being squashed and never report.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            int_meta_q <= '0;
            int_sync_q <= '0;
            code_q     <= '0;
            cp0_pc_q   <= '0;
            ds_q       <= 1'b0;
            bad_addr_q <= '0;
            new_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_meta_q <= int_meta_d;
            int_sync_q <= int_sync_d;
            code_q     <= code_d;
            cp0_pc_q   <= cp0_pc_d;
            ds_q       <= ds_d;
            bad_addr_q <= bad_addr_d;
            new_pc_q   <= new_pc_d;
        end
    end

    assign int_sync_o        = int_sync_q;
    assign excepttype_o      = {27'b0, code_q};
    assign cp0_pc_o          = cp0_pc_q;
    assign is_in_delayslot_o = ds_q;
    assign bad_addr_o        = bad_addr_q;
    assign new_pc_o          = new_pc_q;
    assign flush_o           = (state_q == S_FLUSH);
    assign busy_o            = (state_q == S_FLUSH);

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios with literal expectations plus a random run,
// all cycles checked against a priority-table reference model.
module tb_exc_ctrl;
  localparam logic [31:0] EXC_ENTRY = 32'hBFC00380;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  int_i = '0;
  logic        mem_valid_i = 1'b0, stall_i = 1'b0, mem_in_delayslot_i = 1'b0;
  logic [31:0] mem_pc_i = '0, mem_addr_i = '0;
  logic        adel_if_i = 0, ri_i = 0, ov_i = 0, trap_i = 0, syscall_i = 0;
  logic        break_i = 0, adel_i = 0, ades_i = 0, eret_i = 0;
  logic [31:0] cp0_status_i = '0, cp0_cause_i = '0, cp0_epc_i = '0;
  logic [5:0]  int_sync_o;
  logic [31:0] excepttype_o, cp0_pc_o, bad_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o, busy_o;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  exc_ctrl #(.EXC_ENTRY(EXC_ENTRY), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .int_i(int_i),
    .mem_valid_i(mem_valid_i), .stall_i(stall_i), .mem_pc_i(mem_pc_i),
    .mem_addr_i(mem_addr_i), .mem_in_delayslot_i(mem_in_delayslot_i),
    .adel_if_i(adel_if_i), .ri_i(ri_i), .ov_i(ov_i), .trap_i(trap_i),
    .syscall_i(syscall_i), .break_i(break_i), .adel_i(adel_i), .ades_i(ades_i),
    .eret_i(eret_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .int_sync_o(int_sync_o), .excepttype_o(excepttype_o),
    .cp0_pc_o(cp0_pc_o), .is_in_delayslot_o(is_in_delayslot_o),
    .bad_addr_o(bad_addr_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .busy_o(busy_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: priority table, flush countdown, int history queue
  int          code_tab [10] = '{1, 4, 10, 12, 13, 8, 9, 4, 5, 14};
  int          flush_left = 0;
  logic [31:0] exp_code = '0, exp_pc = '0, exp_bad = '0, exp_new_pc = '0;
  logic        exp_ds = 1'b0;
  logic [5:0]  int_hist[$];

  function automatic int pick();
    logic [9:0] req;
    logic       pend;
    pend = cp0_status_i[0] && !cp0_status_i[1] &&
           ((cp0_cause_i[15:8] & cp0_status_i[15:8]) != 8'h00);
    req = {eret_i, ades_i, adel_i, break_i, syscall_i, trap_i, ov_i, ri_i, adel_if_i, pend};
    for (int i = 0; i < 10; i++) if (req[i]) return i;
    return -1;
  endfunction

  function automatic logic [5:0] sync_exp();
    if (int_hist.size() >= 2) return int_hist[int_hist.size() - 2];
    return 6'h00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_left <= 0;
      exp_code <= '0; exp_pc <= '0; exp_bad <= '0; exp_new_pc <= '0; exp_ds <= 1'b0;
      int_hist.delete();
    end else begin
      int_hist.push_back(int_i);
      if (int_hist.size() > 4) void'(int_hist.pop_front());
      exp_code <= '0;
      if (flush_left > 0) begin
        flush_left <= flush_left - 1;
      end else if (mem_valid_i && !stall_i && pick() >= 0) begin
        exp_code   <= 32'(code_tab[pick()]);
        flush_left <= FLUSH_CYCLES;
        exp_pc     <= mem_pc_i;
        exp_ds     <= mem_in_delayslot_i;
        exp_new_pc <= (pick() == 9) ? cp0_epc_i : EXC_ENTRY;
        if (pick() == 1) exp_bad <= mem_pc_i;
        else if (pick() == 7 || pick() == 8) exp_bad <= mem_addr_i;
      end
    end
  end

  // scoreboard compare, every cycle, mid-cycle like CP0
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("excepttype", excepttype_o, exp_code);
      chk("cp0_pc", cp0_pc_o, exp_pc);
      chk("delayslot", {31'b0, is_in_delayslot_o}, {31'b0, exp_ds});
      chk("bad_addr", bad_addr_o, exp_bad);
      chk("flush", {31'b0, flush_o}, {31'b0, flush_left != 0});
      chk("busy", {31'b0, busy_o}, {31'b0, flush_left != 0});
      chk("int_sync", {26'b0, int_sync_o}, {26'b0, sync_exp()});
      if (flush_left != 0) chk("new_pc", new_pc_o, exp_new_pc);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clear_flags();
    {adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_i, ades_i, eret_i} = '0;
  endtask

  task automatic randomize_inputs();
    int_i              = 6'($urandom_range(0, 63));
    mem_valid_i        = ($urandom_range(0, 3) != 0);
    stall_i            = ($urandom_range(0, 3) == 0);
    mem_pc_i           = $urandom;
    mem_addr_i         = $urandom;
    mem_in_delayslot_i = 1'($urandom_range(0, 1));
    adel_if_i = ($urandom_range(0, 15) == 0);
    ri_i      = ($urandom_range(0, 15) == 0);
    ov_i      = ($urandom_range(0, 15) == 0);
    trap_i    = ($urandom_range(0, 15) == 0);
    syscall_i = ($urandom_range(0, 15) == 0);
    break_i   = ($urandom_range(0, 15) == 0);
    adel_i    = ($urandom_range(0, 15) == 0);
    ades_i    = ($urandom_range(0, 15) == 0);
    eret_i    = ($urandom_range(0, 15) == 0);
    cp0_status_i = {16'h0, 8'($urandom_range(0, 255)), 6'h0, 2'($urandom_range(0, 3))};
    cp0_cause_i  = ($urandom_range(0, 2) == 0) ? {16'h0, 8'($urandom_range(0, 255)), 8'h0} : 32'h0;
    cp0_epc_i    = $urandom;
  endtask

  initial begin
    #3 rst = 1'b0;
    cmp_en = 1'b1;
    // reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      tick();
      chk("rst_excepttype", excepttype_o, 32'h0);
      chk("rst_flush", {31'b0, flush_o}, 32'h0);
      chk("rst_busy", {31'b0, busy_o}, 32'h0);
      chk("rst_int_sync", {26'b0, int_sync_o}, 32'h0);
      chk("rst_new_pc", new_pc_o, 32'h0);
    end
    clear_flags();
    int_i = '0; stall_i = 0; mem_valid_i = 1; cp0_status_i = '0; cp0_cause_i = '0;
    mem_in_delayslot_i = 0;
    rst = 1'b1;
    tick();
    chk("idle_after_rst", {31'b0, flush_o}, 32'h0);

    // syscall
    syscall_i = 1; mem_pc_i = 32'hBFC00100;
    tick();
    chk("sys_code", excepttype_o, 32'h8);
    chk("sys_pc", cp0_pc_o, 32'hBFC00100);
    chk("sys_newpc", new_pc_o, 32'hBFC00380);
    chk("sys_flush1", {31'b0, flush_o}, 32'h1);
    clear_flags();
    tick();
    chk("sys_code_off", excepttype_o, 32'h0);
    chk("sys_flush2", {31'b0, flush_o}, 32'h1);
    tick();
    chk("sys_flush_off", {31'b0, flush_o}, 32'h0);

    // ov beats adel, bad_addr untouched; then adel alone
    adel_i = 1; ov_i = 1; mem_addr_i = 32'h00000003;
    tick();
    chk("ov_code", excepttype_o, 32'hc);
    chk("ov_badaddr", bad_addr_o, 32'h0);
    clear_flags();
    tick(); tick();
    adel_i = 1;
    tick();
    chk("adel_code", excepttype_o, 32'h4);
    chk("adel_badaddr", bad_addr_o, 32'h00000003);
    clear_flags();
    tick(); tick();

    // eret, second eret while busy ignored
    eret_i = 1; cp0_epc_i = 32'h80001234;
    tick();
    chk("eret_code", excepttype_o, 32'he);
    chk("eret_newpc", new_pc_o, 32'h80001234);
    tick();
    chk("eret2_ignored", excepttype_o, 32'h0);
    clear_flags();
    tick();
    chk("eret_flush_off", {31'b0, flush_o}, 32'h0);

    // interrupt beats break; with EXL set break wins
    int_i = 6'h01; cp0_status_i = 32'h00000401; cp0_cause_i = 32'h00000400; break_i = 1;
    tick();
    chk("irq_code", excepttype_o, 32'h1);
    clear_flags();
    tick(); tick();
    chk("int_sync_val", {26'b0, int_sync_o}, 32'h1);
    cp0_status_i = 32'h00000403; break_i = 1;
    tick();
    chk("break_code", excepttype_o, 32'h9);
    clear_flags();
    tick(); tick();

    // stall holds off ri, then accept, then async reset mid-flush
    cp0_status_i = '0; cp0_cause_i = '0; int_i = '0;
    stall_i = 1; ri_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_code", excepttype_o, 32'h0);
      chk("stall_flush", {31'b0, flush_o}, 32'h0);
    end
    stall_i = 0;
    tick();
    chk("ri_code", excepttype_o, 32'ha);
    clear_flags();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_flush", {31'b0, flush_o}, 32'h0);
    chk("async_rst_busy", {31'b0, busy_o}, 32'h0);
    @(negedge clk); #1;
    rst = 1'b1;
    tick();

    // random run
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
